// File: rtl/memory_arbiter_handshake_if.sv
// Request/response bundle shared by the NUM_CH requesters of memory_arbiter_handshake.
// With MEM_PARITY_EN defined the bundle also carries perr_inj_i and perr_o.
interface memory_arbiter_handshake_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 2
);
  logic [NUM_CH-1:0]            valid_i;
  logic [NUM_CH-1:0]            wr_rd_i;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_CH*WIDTH-1:0]      wdata_i;
  logic [NUM_CH-1:0]            ready_o;
  logic [NUM_CH-1:0]            rvalid_o;
  logic [NUM_CH*WIDTH-1:0]      rdata_o;
  logic [NUM_CH-1:0]            err_o;
`ifdef MEM_PARITY_EN
  logic [NUM_CH-1:0]            perr_inj_i;
  logic [NUM_CH-1:0]            perr_o;

  modport master (
    output valid_i, wr_rd_i, addr_i, wdata_i, perr_inj_i,
    input  ready_o, rvalid_o, rdata_o, err_o, perr_o
  );
  modport slave (
    input  valid_i, wr_rd_i, addr_i, wdata_i, perr_inj_i,
    output ready_o, rvalid_o, rdata_o, err_o, perr_o
  );
`else
  modport master (
    output valid_i, wr_rd_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );
  modport slave (
    input  valid_i, wr_rd_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
`endif
endinterface

// File: rtl/memory_arbiter_handshake.sv
// Shared single-port scratch memory: NUM_CH round-robin requesters, RD_LAT-deep read return path.
// Optional MEM_PARITY_EN stores an even-parity bit per word and flags mismatches on read.
module memory_arbiter_handshake #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  memory_arbiter_handshake_if.slave     bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef MEM_PARITY_EN
  localparam int ARR_W = WIDTH + 1;
`else
  localparam int ARR_W = WIDTH;
`endif

  typedef struct packed {
    logic             vld;
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] data;
    logic             oor;
`ifdef MEM_PARITY_EN
    logic             perr;
`endif
  } rd_entry_t;

  logic [ARR_W-1:0]      mem_q [DEPTH];
  logic [ARR_W-1:0]      mem_d [DEPTH];
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]     rvalid_q, rvalid_d;
  logic [NUM_CH*WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0]     err_q, err_d;

  logic [CH_W-1:0]       scan_ch_s [NUM_CH];
  logic [CH_W-1:0]       grant_ch_s;
  logic                  any_req_s;
  logic [NUM_CH-1:0]     grant_s;
  logic                  xfer_s;
  logic                  sel_wr_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [WIDTH-1:0]      sel_wdata_s;
  logic                  in_range_s;
  logic                  wr_en_s;
  logic                  wr_oor_s;
  logic                  rd_en_s;
  logic [ARR_W-1:0]      wr_word_s;
  logic [ARR_W-1:0]      rd_word_s;
  rd_entry_t             acc_s;
  rd_entry_t             ret_s;

  // Channel visit order for this cycle: rr_ptr first, wrapping mod NUM_CH.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      scan_ch_s[i] = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
    end
  end

  // Walk the order backwards so the earliest requester in round-robin order wins.
  always_comb begin
    grant_ch_s = '0;
    any_req_s  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      grant_ch_s = bus.valid_i[scan_ch_s[i]] ? scan_ch_s[i] : grant_ch_s;
      any_req_s  = any_req_s | bus.valid_i[scan_ch_s[i]];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      grant_s[c] = any_req_s && !rst_i && (grant_ch_s == CH_W'(c));
    end
    xfer_s = |grant_s;
  end

  // Route the granted channel's request fields onto the single array port.
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_wr_s    = (grant_ch_s == CH_W'(c)) ? bus.wr_rd_i[c] : sel_wr_s;
      sel_addr_s  = (grant_ch_s == CH_W'(c)) ? bus.addr_i[c*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
      sel_wdata_s = (grant_ch_s == CH_W'(c)) ? bus.wdata_i[c*WIDTH +: WIDTH] : sel_wdata_s;
    end
    in_range_s = ({1'b0, sel_addr_s} < (ADDR_WIDTH+1)'(DEPTH));
    wr_en_s    = xfer_s && sel_wr_s && in_range_s;
    wr_oor_s   = xfer_s && sel_wr_s && !in_range_s;
    rd_en_s    = xfer_s && !sel_wr_s;
  end

`ifdef MEM_PARITY_EN
  logic                  sel_inj_s;
  logic [NUM_CH-1:0]     perr_q, perr_d;

  // Stored parity bit is even parity of the data, optionally inverted to inject an error.
  always_comb begin
    sel_inj_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_inj_s = (grant_ch_s == CH_W'(c)) ? bus.perr_inj_i[c] : sel_inj_s;
    end
    wr_word_s = {(^sel_wdata_s) ^ sel_inj_s, sel_wdata_s};
  end
`else
  assign wr_word_s = sel_wdata_s;
`endif

  // Array next state and read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i]  = (wr_en_s && (sel_addr_s == ADDR_WIDTH'(i))) ? wr_word_s : mem_q[i];
      rd_word_s = (sel_addr_s == ADDR_WIDTH'(i)) ? mem_q[i] : rd_word_s;
    end
  end

  always_comb begin
    acc_s      = '0;
    acc_s.vld  = rd_en_s;
    acc_s.ch   = grant_ch_s;
    acc_s.data = rd_word_s[WIDTH-1:0];
    acc_s.oor  = !in_range_s;
`ifdef MEM_PARITY_EN
    acc_s.perr = ^rd_word_s;
`endif
  end

  // The output registers form the last stage, so only RD_LAT-1 extra stages are needed.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign ret_s = acc_s;
    end else begin : g_latn
      rd_entry_t pipe_q [RD_LAT-1];
      rd_entry_t pipe_d [RD_LAT-1];

      always_comb begin
        pipe_d[0] = acc_s;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_q <= '{default: '0};
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign ret_s = pipe_q[RD_LAT-2];
    end
  endgenerate

  always_comb begin
    if (xfer_s) begin
      if (grant_ch_s == CH_W'(NUM_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_ch_s + CH_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Per-channel return decode; rdata slices hold until their channel's next return.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = '0;
`ifdef MEM_PARITY_EN
    perr_d   = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      rvalid_d[c] = ret_s.vld && (ret_s.ch == CH_W'(c));
      rdata_d[c*WIDTH +: WIDTH] = rvalid_d[c] ? ret_s.data : rdata_q[c*WIDTH +: WIDTH];
      err_d[c] = (rvalid_d[c] && ret_s.oor) || (wr_oor_s && (grant_ch_s == CH_W'(c)));
`ifdef MEM_PARITY_EN
      perr_d[c] = rvalid_d[c] && ret_s.perr;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
`ifdef MEM_PARITY_EN
      perr_q   <= '0;
`endif
    end else begin
      mem_q    <= mem_d;
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef MEM_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign bus.ready_o  = grant_s;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;
`ifdef MEM_PARITY_EN
  assign bus.perr_o   = perr_q;
`endif

endmodule
